pc_fetch_unit: RTL
==================

Name: pc_fetch_unit

Overview:
- Fetch/next-PC stage of the RV32I core. Owns the program counter and issues word fetches to instruction memory over a req/ack handshake.
- Hands fetched instructions to decode over valid/ready.
- Consumes the `branch` result of the branch comparison unit, together with the execute-stage control-flow flags, to redirect fetch on taken branches, JAL and JALR.
- Discards wrong-path instructions on every redirect.

Parameters:
- XLEN, 32, datapath/address width (shared header value).
- RESET_VECTOR, 32'h0000_0000, PC value after reset.
- TRAP_VECTOR, 32'h0000_0004, redirect target on misaligned trap (optional feature only).

Ports:
- clk  in  1  core clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request; held until imem_ack.
- imem_addr  out  XLEN  fetch address; stable while imem_req high.
- imem_ack  in  1  request accepted; imem_rdata valid this cycle.
- imem_rdata  in  32  fetched instruction word.
- instr_valid  out  1  instruction available to decode.
- instr  out  32  instruction word.
- instr_pc  out  XLEN  address of instr.
- instr_ready  in  1  decode accepts instr this cycle.
- ex_valid  in  1  execute stage holds a valid instruction.
- ex_pc  in  XLEN  PC of execute-stage instruction.
- ex_is_branch  in  1  conditional branch.
- ex_is_jal  in  1  JAL.
- ex_is_jalr  in  1  JALR.
- branch  in  1  comparison result from branch comparison unit.
- ex_imm  in  XLEN  sign-extended immediate.
- ex_rs1  in  XLEN  rs1 value (JALR base).
- ex_link  out  XLEN  ex_pc+4, combinational (rd write value for JAL/JALR).
- redirect  out  1  combinational; flush request to decode/execute.

Behaviour:
- redirect = ex_valid & (ex_is_jal | ex_is_jalr | (ex_is_branch & branch)).
- Target, mod 2^XLEN:
  - branch/JAL: ex_pc + ex_imm.
  - JALR: (ex_rs1 + ex_imm) with bit0 cleared.
  - If more than one ex_is_* flag is set, JALR has priority, then JAL.
- Registers: pc, fetch_addr, out buffer (instr, instr_pc, instr_valid), 2-bit state.
- Reset values: pc = RESET_VECTOR, fetch_addr = RESET_VECTOR, state = FETCH, imem_req = 0 during the reset cycle, instr_valid = 0, instr = 0, instr_pc = 0.
- imem_req = 1 in FETCH and DRAIN, otherwise 0. imem_addr = fetch_addr.
- FETCH:
  - ack & !redirect: buffer <= {imem_rdata, fetch_addr}, instr_valid <= 1, pc <= fetch_addr+4 → HOLD.
  - ack & redirect: data dropped; pc <= target; fetch_addr <= target; stay FETCH.
  - !ack & redirect: pc <= target → DRAIN (fetch_addr unchanged; address stays stable).
  - !ack & !redirect: stay FETCH.
- HOLD:
  - redirect, with or without instr_ready (redirect wins): instr_valid <= 0; pc, fetch_addr <= target → FETCH.
  - instr_ready: instr_valid <= 0; fetch_addr <= pc → FETCH.
  - Otherwise hold; outputs stable.
- DRAIN:
  - On ack: data dropped; fetch_addr <= pc → FETCH.
  - Further redirect in DRAIN: pc <= newest target.
  - Redirect in the same cycle as ack: fetch_addr <= that target.
- Latency:
  - Ack in cycle N → instr_valid in N+1.
  - Handshake in cycle M → next imem_req in M+1.
  - Redirect in cycle N → request to target no earlier than N+1.
- instr_valid is never asserted for an instruction fetched before a redirect.
- rst mid-transaction: state returns to FETCH at RESET_VECTOR. Outstanding-ack cleanup is the memory's responsibility; the memory resets on the same rst.

Optional Feature:
- MISALIGN_TRAP_EN defined:
  - A redirect whose target[1:0] != 0 goes to TRAP_VECTOR instead.
  - Extra outputs: trap_pulse (1 cycle, registered) and trap_addr (offending target, held until the next trap).
  - Both reset to 0.
- Undefined: target[1:0] forced to 00; no trap ports.

Decomposition:
- Shared package/header holds:
  - XLEN.
  - FSM state encodings FETCH/HOLD/DRAIN.
  - Default RESET_VECTOR and TRAP_VECTOR.
- Sub-module pc_target_calc: combinational target select, JALR bit-clear and ex_link; unit-testable on its own.

Test Plan:
- Reset, ack 1 cycle after each req, instr_ready tied 1 → imem_addr 0x0, 0x4, 0x8 with instr_pc matching and no gaps in sequence.
- In HOLD, ex_is_branch=1, branch=1, ex_pc=0x100, ex_imm=0xFFFFFFF0 → next imem_addr 0xF0, instr_valid drops next cycle.
- JALR with ex_rs1=0x203, ex_imm=0 → target 0x202 (feature off: 0x200). Feature on: imem_addr=0x4, trap_pulse one cycle, trap_addr=0x202.
- Redirect to 0x40 while req for 0x8 is unacked, ack 3 cycles later → 0x8 data dropped, next request 0x40, instr_valid never shows 0x8.
- HOLD with instr_ready=0 for 5 cycles → instr/instr_pc stable, imem_req=0; redirect and instr_ready together → buffer dropped, fetch target.
- Assert rst while in DRAIN → next cycle instr_valid=0, state FETCH, imem_addr=RESET_VECTOR.

Source files
------------

// File: rtl/pc_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch_unit_pkg
// Brief    : Shared widths, reset/trap vectors and fetch FSM encodings.
// Revision : 1.0 - initial release
// ============================================================================
package pc_fetch_unit_pkg;

    localparam int c_XLEN      = 32;
    localparam int c_STATE_W   = 2;

    localparam logic [c_XLEN-1:0] c_RESET_VECTOR = 32'h0000_0000;
    localparam logic [c_XLEN-1:0] c_TRAP_VECTOR  = 32'h0000_0004;

    localparam logic [c_STATE_W-1:0] c_ST_FETCH = 2'd0;
    localparam logic [c_STATE_W-1:0] c_ST_HOLD  = 2'd1;
    localparam logic [c_STATE_W-1:0] c_ST_DRAIN = 2'd2;

    typedef enum logic [c_STATE_W-1:0] {
        FETCH = c_ST_FETCH,
        HOLD  = c_ST_HOLD,
        DRAIN = c_ST_DRAIN
    } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/pc_fetch_unit_target_calc.sv
`default_nettype none
// ============================================================================
// Module   : pc_target_calc
// Brief    : Redirect target select (JALR over JAL/branch) and link value.
// Revision : 1.0 - initial release
// ============================================================================
module pc_target_calc
    import pc_fetch_unit_pkg::*;
#(
    parameter int XLEN = c_XLEN
) (
    input  logic [XLEN-1:0] i_ex_pc,
    input  logic [XLEN-1:0] i_ex_imm,
    input  logic [XLEN-1:0] i_ex_rs1,
    input  logic            i_ex_is_jalr,
    output logic [XLEN-1:0] o_target,
    output logic [XLEN-1:0] o_link
);

    logic [XLEN-1:0] w_base;
    logic [XLEN-1:0] w_sum;

    // JAL and conditional branches share the pc-relative adder, so only JALR changes the base.
    assign w_base   = i_ex_is_jalr ? i_ex_rs1 : i_ex_pc;
    assign w_sum    = w_base + i_ex_imm;
    assign o_target = i_ex_is_jalr ? {w_sum[XLEN-1:1], 1'b0} : w_sum;
    assign o_link   = i_ex_pc + XLEN'(4);

endmodule
`default_nettype wire

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch_unit
// Brief    : PC owner and instruction fetch stage with redirect/flush handling.
// Options  : MISALIGN_TRAP_EN - misaligned redirect targets trap to TRAP_VECTOR.
// Revision : 1.0 - initial release
// ============================================================================
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter int              XLEN         = c_XLEN,
    parameter logic [XLEN-1:0] RESET_VECTOR = c_RESET_VECTOR
`ifdef MISALIGN_TRAP_EN
    ,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = c_TRAP_VECTOR
`endif
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic            instr_valid,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            instr_ready,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_pc,
    input  logic            ex_is_branch,
    input  logic            ex_is_jal,
    input  logic            ex_is_jalr,
    input  logic            branch,
    input  logic [XLEN-1:0] ex_imm,
    input  logic [XLEN-1:0] ex_rs1,
    output logic [XLEN-1:0] ex_link,
    output logic            redirect
`ifdef MISALIGN_TRAP_EN
    ,
    output logic            trap_pulse,
    output logic [XLEN-1:0] trap_addr
`endif
);

    fetch_state_e    r_state, w_state_nxt;
    logic [XLEN-1:0] r_pc, w_pc_nxt;
    logic [XLEN-1:0] r_fetch_addr, w_fetch_addr_nxt;
    logic [XLEN-1:0] r_instr_pc, w_instr_pc_nxt;
    logic [31:0]     r_instr, w_instr_nxt;
    logic            r_instr_valid, w_instr_valid_nxt;
    logic [XLEN-1:0] w_raw_target;
    logic [XLEN-1:0] w_target;
    logic            w_redirect;

    pc_target_calc #(
        .XLEN         (XLEN)
    ) u_target_calc (
        .i_ex_pc      (ex_pc),
        .i_ex_imm     (ex_imm),
        .i_ex_rs1     (ex_rs1),
        .i_ex_is_jalr (ex_is_jalr),
        .o_target     (w_raw_target),
        .o_link       (ex_link)
    );

    assign w_redirect = ex_valid & (ex_is_jal | ex_is_jalr | (ex_is_branch & branch));

`ifdef MISALIGN_TRAP_EN
    logic            w_misaligned;
    logic            r_trap_pulse;
    logic [XLEN-1:0] r_trap_addr;

    assign w_misaligned = |w_raw_target[1:0];
    assign w_target     = w_misaligned ? TRAP_VECTOR : w_raw_target;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_trap_pulse <= 1'b0;
            r_trap_addr  <= '0;
        end else begin
            r_trap_pulse <= w_redirect & w_misaligned;
            if (w_redirect & w_misaligned) begin
                r_trap_addr <= w_raw_target;
            end
        end
    end

    assign trap_pulse = r_trap_pulse;
    assign trap_addr  = r_trap_addr;
`else
    assign w_target = w_raw_target & ~XLEN'(3);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= FETCH;
            r_pc          <= RESET_VECTOR;
            r_fetch_addr  <= RESET_VECTOR;
            r_instr_valid <= 1'b0;
            r_instr       <= '0;
            r_instr_pc    <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_fetch_addr  <= w_fetch_addr_nxt;
            r_instr_valid <= w_instr_valid_nxt;
            r_instr       <= w_instr_nxt;
            r_instr_pc    <= w_instr_pc_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_fetch_addr_nxt  = r_fetch_addr;
        w_instr_valid_nxt = r_instr_valid;
        w_instr_nxt       = r_instr;
        w_instr_pc_nxt    = r_instr_pc;
        case (r_state)
            FETCH: begin
                if (imem_ack && w_redirect) begin
                    w_pc_nxt         = w_target;
                    w_fetch_addr_nxt = w_target;
                end else if (imem_ack) begin
                    w_instr_nxt       = imem_rdata;
                    w_instr_pc_nxt    = r_fetch_addr;
                    w_instr_valid_nxt = 1'b1;
                    w_pc_nxt          = r_fetch_addr + XLEN'(4);
                    w_state_nxt       = HOLD;
                end else if (w_redirect) begin
                    // Request already on the bus must complete at its address; its data is discarded.
                    w_pc_nxt    = w_target;
                    w_state_nxt = DRAIN;
                end
            end
            HOLD: begin
                if (w_redirect) begin
                    w_instr_valid_nxt = 1'b0;
                    w_pc_nxt          = w_target;
                    w_fetch_addr_nxt  = w_target;
                    w_state_nxt       = FETCH;
                end else if (instr_ready) begin
                    w_instr_valid_nxt = 1'b0;
                    w_fetch_addr_nxt  = r_pc;
                    w_state_nxt       = FETCH;
                end
            end
            DRAIN: begin
                if (w_redirect) begin
                    w_pc_nxt = w_target;
                end
                if (imem_ack) begin
                    w_fetch_addr_nxt = w_redirect ? w_target : r_pc;
                    w_state_nxt      = FETCH;
                end
            end
            default: begin
                w_state_nxt = FETCH;
            end
        endcase
    end

    assign imem_req    = ~rst & ((r_state == FETCH) | (r_state == DRAIN));
    assign imem_addr   = r_fetch_addr;
    assign instr_valid = r_instr_valid;
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;
    assign redirect    = w_redirect;

endmodule
`default_nettype wire
